// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_queue
//  Description : Writeback-side consumer of the EX/WB latch. Selects the
//                writeback value, queues pending register writes, drains them
//                in order to the shared register-file write port when granted,
//                provides youngest-match forwarding and counts retirements.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_mem,
    input  logic [XLEN-1:0]   in_vdot,
    input  logic [1:0]        in_sel,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              rf_grant,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [ADDR_W-1:0] fwd_rs,
    output logic              fwd_hit,
    output logic [XLEN-1:0]   fwd_data,
    output logic              q_empty,
    output logic              q_full,
    output logic [31:0]       retire_cnt
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    // Queue storage: destination register and writeback value per entry
    logic [ADDR_W-1:0]  r_rd   [DEPTH];
    logic [XLEN-1:0]    r_data [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_retire;

    logic [XLEN-1:0]    w_value;
    logic               w_accept;
    logic               w_store;
    logic               w_drop;
    logic               w_pop;
    logic [1:0]         w_retire_inc;
    logic [c_PTR_W-1:0] w_idx;

    assign q_empty    = (r_count == '0);
    assign q_full     = (r_count == c_FULL);
    // Ready depends on registered occupancy only, so a pop never frees a slot
    // for an accept in the same cycle.
    assign in_ready   = !q_full;
    assign w_accept   = in_valid && in_ready;
    // Writes to x0 are architecturally dead and never occupy a slot.
    assign w_store    = w_accept && in_we && (in_rd != '0);
    assign w_drop     = w_accept && !w_store;
    assign rf_we      = !q_empty && rf_grant;
    assign w_pop      = rf_we;
    assign rf_addr    = q_empty ? '0 : r_rd[r_head];
    assign rf_wdata   = q_empty ? '0 : r_data[r_head];
    assign retire_cnt = r_retire;
    // A dropped accept and a commit can both retire in one cycle.
    assign w_retire_inc = {1'b0, w_drop} + {1'b0, w_pop};

    // Writeback value select; PC+4 wraps naturally at XLEN bits
    always_comb begin
        w_value = in_alu;
        case (in_sel)
            2'b00:   w_value = in_alu;
            2'b01:   w_value = in_mem;
            2'b10:   w_value = in_pc + XLEN'(4);
            default: w_value = in_vdot;
        endcase
    end

    // Pointer and occupancy bookkeeping; reset discards every queued write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry payload; only occupied slots are ever observed, so no reset needed
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_rd[r_tail]   <= in_rd;
            r_data[r_tail] <= w_value;
        end
    end

    // Retired-instruction counter, wraps at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire <= '0;
        end else begin
            r_retire <= r_retire + 32'(w_retire_inc);
        end
    end

    // Forwarding scan from oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) && (fwd_rs != '0) && (r_rd[w_idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_commit_queue
//  Description : Self-checking bench for wb_commit_queue: directed vector
//                table, hand-written corner sequences and randomized traffic
//                compared against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_commit_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_mem = '0;
    logic [31:0] in_vdot = '0;
    logic [1:0]  in_sel = '0;
    logic [4:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic        rf_grant = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [4:0]  fwd_rs = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        q_empty;
    logic        q_full;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    wb_commit_queue #(.DEPTH(4), .XLEN(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_alu     (in_alu),
        .in_mem     (in_mem),
        .in_vdot    (in_vdot),
        .in_sel     (in_sel),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .rf_grant   (rf_grant),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .q_empty    (q_empty),
        .q_full     (q_full),
        .retire_cnt (retire_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_commits = 0;

    // Reference model: pending writes in acceptance order plus a retire tally
    logic [4:0]  mq_rd   [$];
    logic [31:0] mq_data [$];
    logic [31:0] m_retire = '0;

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        grant;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_ret;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic [31:0] mem,
                                             input logic [31:0] vdot);
        case (sel)
            2'd0:    return alu;
            2'd1:    return mem;
            2'd2:    return pc + 32'd4;
            default: return vdot;
        endcase
    endfunction

    // Settle inputs, then compare every output against the model
    task automatic pre();
        logic        m_empty;
        logic        m_hit;
        logic [31:0] m_fdata;
        #2;
        m_empty = (mq_rd.size() == 0);
        m_hit   = 1'b0;
        m_fdata = '0;
        for (int i = mq_rd.size() - 1; i >= 0; i--) begin
            if (fwd_rs != 5'd0 && mq_rd[i] == fwd_rs) begin
                m_hit   = 1'b1;
                m_fdata = mq_data[i];
                break;
            end
        end
        chk("in_ready", 32'(in_ready), 32'(mq_rd.size() < 4));
        chk("q_empty", 32'(q_empty), 32'(m_empty));
        chk("q_full", 32'(q_full), 32'(mq_rd.size() == 4));
        chk("rf_we", 32'(rf_we), 32'(!m_empty && rf_grant));
        chk("rf_addr", 32'(rf_addr), m_empty ? 32'd0 : 32'(mq_rd[0]));
        chk("rf_wdata", rf_wdata, m_empty ? 32'd0 : mq_data[0]);
        chk("fwd_hit", 32'(fwd_hit), 32'(m_hit));
        if (m_hit) chk("fwd_data", fwd_data, m_fdata);
        chk("retire_cnt", retire_cnt, m_retire);
        if (rf_we === 1'b1) n_commits++;
    endtask

    // Advance one clock edge and apply the architectural rules to the model
    task automatic post();
        logic acc;
        logic pop;
        acc = in_valid && (mq_rd.size() < 4);
        pop = (mq_rd.size() > 0) && rf_grant;
        @(posedge clk);
        if (pop) begin
            void'(mq_rd.pop_front());
            void'(mq_data.pop_front());
            m_retire++;
        end
        if (acc) begin
            if (in_we && in_rd != 5'd0) begin
                mq_rd.push_back(in_rd);
                mq_data.push_back(wb_value(in_sel, in_pc, in_alu, in_mem, in_vdot));
            end else begin
                m_retire++;
            end
        end
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rf_grant = 1'b1;
        for (int c = 0; c < 20 && mq_rd.size() > 0; c++) begin
            pre();
            post();
        end
        chk("drain_empty", 32'(q_empty), 32'd1);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] alu);
        in_valid = 1'b1;
        in_we    = 1'b1;
        in_sel   = 2'd0;
        in_rd    = rd;
        in_alu   = alu;
        pre();
        post();
        in_valid = 1'b0;
    endtask

    initial begin
        // Sel-mux stream with immediate grant, followed by dropped accepts
        tbl[0] = '{1'b1, 2'd0, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,   32'd0};
        tbl[1] = '{1'b1, 2'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11,  32'd0};
        tbl[2] = '{1'b1, 2'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd2, 32'h22,  32'd1};
        tbl[3] = '{1'b1, 2'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 32'h104, 32'd2};
        tbl[4] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44,  32'd3};
        tbl[5] = '{1'b1, 2'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,   32'd4};
        tbl[6] = '{1'b1, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,   32'd5};
        tbl[7] = '{1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,   32'd6};

        // Reset held: outputs at their reset values
        #3;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_q_empty", 32'(q_empty), 32'd1);
        chk("rst_q_full", 32'(q_full), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            pre();
            post();
        end

        // Table-driven: value select and drop behaviour
        in_pc = 32'h100; in_alu = 32'h11; in_mem = 32'h22; in_vdot = 32'h44;
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].vld;
            in_sel   = tbl[i].sel;
            in_rd    = tbl[i].rd;
            in_we    = tbl[i].we;
            rf_grant = tbl[i].grant;
            pre();
            chk($sformatf("tbl%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_rf_addr", i), 32'(rf_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].e_data);
            chk($sformatf("tbl%0d_retire", i), retire_cnt, tbl[i].e_ret);
            post();
        end
        in_valid = 1'b0;

        // Forwarding: youngest match, x0 never hits, same-cycle accept excluded
        rf_grant = 1'b0;
        push(5'd5, 32'hA);
        push(5'd5, 32'hB);
        fwd_rs = 5'd5;
        pre();
        chk("fwd_young_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_young_data", fwd_data, 32'hB);
        post();
        fwd_rs = 5'd0;
        pre();
        chk("fwd_x0_miss", 32'(fwd_hit), 32'd0);
        post();
        fwd_rs = 5'd6;
        in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd6; in_alu = 32'hC; in_sel = 2'd0;
        pre();
        chk("fwd_same_cycle_miss", 32'(fwd_hit), 32'd0);
        post();
        in_valid = 1'b0;
        pre();
        chk("fwd_after_accept_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_after_accept_data", fwd_data, 32'hC);
        post();
        fwd_rs = 5'd5;
        drain();

        // Backpressure: fill, hold a fifth, release grant
        rf_grant  = 1'b0;
        n_commits = 0;
        for (int k = 0; k < 4; k++) push(5'(8 + k), 32'h300 + 32'(k));
        in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd12; in_alu = 32'h304;
        pre();
        chk("bp_full", 32'(q_full), 32'd1);
        chk("bp_not_ready", 32'(in_ready), 32'd0);
        post();
        rf_grant = 1'b1;
        pre();
        chk("bp_pop_no_bypass", 32'(in_ready), 32'd0);
        chk("bp_pop_we", 32'(rf_we), 32'd1);
        post();
        pre();
        chk("bp_fifth_ready", 32'(in_ready), 32'd1);
        post();
        drain();
        chk("bp_commits", 32'(n_commits), 32'd5);

        // Asynchronous reset pulse with writes pending
        rf_grant = 1'b0;
        fwd_rs   = 5'd9;
        push(5'd9, 32'h901);
        push(5'd10, 32'h902);
        push(5'd11, 32'h903);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(q_empty), 32'd1);
        chk("arst_fwd", 32'(fwd_hit), 32'd0);
        chk("arst_retire", retire_cnt, 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        mq_rd.delete();
        mq_data.delete();
        m_retire = '0;
        rf_grant = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pre();
            chk("arst_no_we", 32'(rf_we), 32'd0);
            post();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_we    = ($urandom_range(0, 4) != 0);
            in_sel   = 2'($urandom_range(0, 3));
            in_rd    = 5'($urandom_range(0, 7));
            in_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            in_alu   = $urandom;
            in_mem   = $urandom;
            in_vdot  = $urandom;
            rf_grant = ($urandom_range(0, 2) != 0);
            fwd_rs   = 5'($urandom_range(0, 7));
            pre();
            post();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
